// File: rtl/norm_clk.sv
// Normalising shifter: b << pin with exponent and zero flag, two-stage valid/ready pipe.
// Optional macro NORM_SKID_EN registers ready behind a one-entry skid buffer.
module norm_clk #(
  parameter int bits_in  = 16,
  parameter int bits_out = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [bits_in-1:0]  b,
  input  logic [bits_out-1:0] pin,
  input  logic                vin,
  output logic                ready,
  output logic [bits_in-1:0]  mant,
  output logic [bits_out-1:0] exp,
  output logic                zero,
  output logic                vout,
  input  logic                oready
);

  logic                v1, z1;
  logic [bits_in-1:0]  b1;
  logic [bits_out-1:0] p1;
  logic                en1, en2;

  // beat presented to S1 this cycle (direct input or skid entry)
  logic                s_v;
  logic [bits_in-1:0]  s_b;
  logic [bits_out-1:0] s_p;

  assign en2 = !vout || oready;
  assign en1 = !v1 || en2;

`ifdef NORM_SKID_EN
  logic                kv, kv_n, rdy_q, acc;
  logic [bits_in-1:0]  kb;
  logic [bits_out-1:0] kp;

  assign ready = rdy_q;
  assign acc   = vin && rdy_q;

  // skid entry wins S1; ready is held low while it is occupied
  always_comb begin
    s_v  = acc;
    s_b  = b;
    s_p  = pin;
    kv_n = kv;
    if (kv) begin
      s_v = 1'b1;
      s_b = kb;
      s_p = kp;
      if (en1) kv_n = 1'b0;
    end else if (acc && !en1) begin
      kv_n = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      kv    <= 1'b0;
      kb    <= '0;
      kp    <= '0;
      rdy_q <= 1'b1;
    end else begin
      kv    <= kv_n;
      rdy_q <= !kv_n;
      if (!kv && acc && !en1) begin
        kb <= b;
        kp <= pin;
      end
    end
  end
`else
  assign ready = en1;

  always_comb begin
    s_v = vin;
    s_b = b;
    s_p = pin;
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1 <= 1'b0;
      b1 <= '0;
      p1 <= '0;
      z1 <= 1'b0;
    end else if (en1) begin
      v1 <= s_v;
      if (s_v) begin
        b1 <= s_b;
        p1 <= s_p;
        z1 <= (s_b == '0);
      end
    end
  end

  logic [bits_in-1:0]  sh;
  logic [bits_out-1:0] exp_n;

  always_comb begin
    sh = b1;
    for (int unsigned i = 0; i < bits_out; i++) begin
      if (p1[i]) sh = sh << (1 << i);
    end
    exp_n = bits_out'(bits_in - 1) - p1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vout <= 1'b0;
      mant <= '0;
      exp  <= '0;
      zero <= 1'b0;
    end else if (en2) begin
      vout <= v1;
      if (v1) begin
        mant <= z1 ? '0 : sh;
        exp  <= z1 ? '0 : exp_n;
        zero <= z1;
      end
    end
  end

endmodule

// File: doc/norm_clk.md
# norm_clk

Normalising shifter that sits directly downstream of the clocked count-leading-zeros stage in the reciprocal/Newton datapath. It takes the operand `b` together with its leading-zero count and left-shifts `b` so that its MSB is set. It also produces the binary exponent (position of the original MSB) and a zero flag. It is a two-stage valid/ready pipeline with full backpressure, so the Newton iteration seed logic can stall it.

## Interface
- `bits_in`, 16: operand and mantissa width; power of two, at least 4.
- `bits_out`, 4: count/exponent width; must equal log2(`bits_in`).
- `clk`  in  1  clock; all state updates on rising edge.
- `rst`  in  1  reset; asynchronous, active-high.
- `b`  in  `bits_in`  operand, same value presented to the clz stage.
- `pin`  in  `bits_out`  leading-zero count from the clz stage.
- `vin`  in  1  `b`/`pin` valid.
- `ready`  out  1  block can accept a beat this cycle.
- `mant`  out  `bits_in`  normalised mantissa, `b << pin`.
- `exp`  out  `bits_out`  `bits_in-1-pin`; 0 when zero.
- `zero`  out  1  operand was all-zero.
- `vout`  out  1  `mant`/`exp`/`zero` valid.
- `oready`  in  1  downstream accepts the output beat.

## Operation
- Input transfer occurs when `vin && ready`. Output transfer occurs when `vout && oready`.
- **Stage S1** registers `{b, pin, zero1}`, where `zero1 = (b == 0)` is computed locally. The block does not trust `pin` for zero detection.
- **Stage S2** registers:
  - `mant = zero1 ? 0 : b << pin`, computed as a log2-stage barrel shift, combinational between S1 and S2.
  - `exp = zero1 ? 0 : bits_in-1-pin`, computed modulo 2^`bits_out`.
  - `zero = zero1`.
- `pin` is used as given; no consistency check against `b`. If `pin` over-counts, bits shifted out are lost.
- Stage enables:
  - `en2 = !v2 || oready`
  - `en1 = !v1 || en2`
  - Without skid: `ready = en1`.
- Each stage's valid bit loads its upstream valid when that stage is enabled, and holds otherwise. Data registers load only when enabled *and* the upstream valid is 1.
- With no `vin`, bubbles propagate and `vout` falls after the last beat drains.
- **Reset:** `v1`, `v2`, `vout`, `zero`, `mant` and `exp` all clear to 0 immediately. Any in-flight beats are discarded. `ready` is 1 while reset is deasserted with an empty pipe.
- `rst` asserted mid-transfer discards that beat. There is no partial output.

## Timing
- Latency: a beat accepted at rising edge N has `vout` = 1 after edge N+2, with no stall.
- Throughput: one beat per cycle while `oready` = 1.
- **Stall:** while `vout && !oready`, `mant`, `exp` and `zero` are held stable and `vout` stays 1. Outputs must not change until the transfer completes.
- Full pipe (`v1` = `v2` = 1) with `oready` = 0 gives `ready` = 0 in the same cycle.
- Simultaneous accept and emit on one edge is legal: there is no bubble inserted and no beat is lost.
- Without the macro, `ready` is combinational from `oready`.

## Configuration
- Macro: `NORM_SKID_EN`.
- **Defined:** `ready` is a register output with no combinational path from `oready`.
  - A one-entry skid register at the S1 input captures the beat accepted in the cycle `ready` was still 1 while the pipe was blocked.
  - `ready` = 1 when the skid is empty. It falls on the edge after the skid captures a beat.
  - When the pipe drains, the skid beat has priority into S1; new input waits.
  - Latency is unchanged when the skid is empty; a beat that passes through the skid sees +1 cycle.
  - Reset clears the skid.
- **Undefined:** no skid register; `ready = en1` as in Operation.

## Test plan
- `b=16'hFFFF, pin=0` with `oready`=1 → `mant=16'hFFFF, exp=15, zero=0`, `vout` exactly two edges after accept.
- `b=16'h00FF, pin=8`, then `b=16'hFF00, pin=0`, then `b=16'h0001, pin=15` on back-to-back cycles → outputs `16'hFF00`/7, `16'hFF00`/15, `16'h8000`/0 on three consecutive cycles.
- `b=16'h0000, pin=15` → `mant=0, exp=0, zero=1`. Also `pin=0` with zero `b` → same result.
- Stream of 5 beats, `oready`=0 for 4 cycles mid-stream → outputs held stable, `ready` falls when the pipe is full (without the macro: same cycle; with the macro: the edge after the skid fills). All 5 beats emerge in order with none dropped or duplicated.
- `rst` pulsed asynchronously between edges with 2 beats in flight → `vout`=0 immediately; no stale beat appears after release; the next accepted beat has normal 2-cycle latency.
- `vin`=1 with `ready`=0 for 3 cycles while `b` changes → only the value present on the accepting edge is emitted.
